// File: rtl/vid_term.sv
// vid_term: text-terminal engine in front of the 1 KB video buffer.
// It takes a byte stream over valid/ready, keeps a cursor, and writes
// characters into video RAM. Line wrap, scroll-up and clear-screen are
// done here, so a CPU can print with one byte write.
//
// state        | meaning
// -------------+----------------------------------------------------
// IDLE         | waiting for a byte; the only state with char_ready=1
// PUT_ISSUE    | write the printable byte at the cursor
// PUT_WAIT     | wait for that write, then advance, wrap or scroll
// SC_RD_ISSUE  | scroll: read the source cell (rows 1..27)
// SC_RD_WAIT   | scroll: capture the read data when the buffer is ready
// SC_WR_ISSUE  | scroll: write the captured byte one row up
// SC_WR_WAIT   | scroll: wait for that write, step the source address
// SC_BLK_ISSUE | scroll: write BLANK into the last visible row
// SC_BLK_WAIT  | scroll: wait for the blank write
// CLR_ISSUE    | clear: write BLANK to the current cell
// CLR_WAIT     | clear: wait for the write, step or finish
module vid_term #(
  parameter int          COLS  = 32,
  parameter int          ROWS  = 28,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       v_sel,
  output logic       v_we,
  output logic [9:0] v_addr,
  output logic [7:0] v_din,
  input  logic [7:0] v_dout,
  input  logic       v_rdy,
  output logic [4:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam logic [4:0] LAST_COL   = 5'(COLS - 1);
  localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);
  localparam logic [9:0] LAST_ADDR  = 10'(ROWS * COLS - 1);
  localparam logic [9:0] FIRST_SRC  = 10'(COLS);
  localparam logic [9:0] LAST_START = 10'((ROWS - 1) * COLS);
  localparam logic [9:0] ROW_STEP   = 10'(COLS);

  typedef enum logic [3:0] {
    IDLE, PUT_ISSUE, PUT_WAIT,
    SC_RD_ISSUE, SC_RD_WAIT, SC_WR_ISSUE, SC_WR_WAIT,
    SC_BLK_ISSUE, SC_BLK_WAIT,
    CLR_ISSUE, CLR_WAIT
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] col, col_nxt;
  logic [4:0] row, row_nxt;
  logic [9:0] addr, addr_nxt;   // scroll source / blank / clear address
  logic [7:0] data, data_nxt;   // character to put, or byte read during scroll

  logic       ready_c, sel_c, we_c;
  logic [9:0] addr_c;
  logic [7:0] din_c;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      addr  <= addr_nxt;
      data  <= data_nxt;
    end
  end

  // Next-state, cursor/address updates and bus drive.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    addr_nxt  = addr;
    data_nxt  = data;
    ready_c   = 1'b0;
    sel_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = addr;
    din_c     = data;

    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (char_valid) begin
          if (char_data >= 8'h20) begin
            data_nxt  = char_data;
            state_nxt = PUT_ISSUE;
          end else begin
            case (char_data)
              8'h0D: col_nxt = '0;
              8'h0A: begin
                if (row == LAST_ROW) begin
                  addr_nxt  = FIRST_SRC;
                  state_nxt = SC_RD_ISSUE;
                end else begin
                  row_nxt = row + 5'd1;
                end
              end
              8'h08: if (col != '0) col_nxt = col - 5'd1;
              8'h0C: begin
                addr_nxt  = '0;
                state_nxt = CLR_ISSUE;
              end
              default: ;  // other control bytes are consumed silently
            endcase
          end
        end
      end

      PUT_ISSUE: begin
        sel_c     = 1'b1;
        we_c      = 1'b1;
        addr_c    = {row, col};
        din_c     = data;
        state_nxt = PUT_WAIT;
      end

      PUT_WAIT: begin
        if (v_rdy) begin
          state_nxt = IDLE;
          if (col == LAST_COL) begin
            col_nxt = '0;
            if (row == LAST_ROW) begin
              addr_nxt  = FIRST_SRC;
              state_nxt = SC_RD_ISSUE;
            end else begin
              row_nxt = row + 5'd1;
            end
          end else begin
            col_nxt = col + 5'd1;
          end
        end
      end

      SC_RD_ISSUE: begin
        sel_c     = 1'b1;
        addr_c    = addr;
        state_nxt = SC_RD_WAIT;
      end

      SC_RD_WAIT: begin
        // Read data is only valid in the cycle v_rdy is high.
        if (v_rdy) begin
          data_nxt  = v_dout;
          state_nxt = SC_WR_ISSUE;
        end
      end

      SC_WR_ISSUE: begin
        sel_c     = 1'b1;
        we_c      = 1'b1;
        addr_c    = addr - ROW_STEP;
        din_c     = data;
        state_nxt = SC_WR_WAIT;
      end

      SC_WR_WAIT: begin
        if (v_rdy) begin
          if (addr == LAST_ADDR) begin
            addr_nxt  = LAST_START;
            state_nxt = SC_BLK_ISSUE;
          end else begin
            addr_nxt  = addr + 10'd1;
            state_nxt = SC_RD_ISSUE;
          end
        end
      end

      SC_BLK_ISSUE: begin
        sel_c     = 1'b1;
        we_c      = 1'b1;
        addr_c    = addr;
        din_c     = BLANK;
        state_nxt = SC_BLK_WAIT;
      end

      SC_BLK_WAIT: begin
        if (v_rdy) begin
          if (addr == LAST_ADDR) begin
            state_nxt = IDLE;
          end else begin
            addr_nxt  = addr + 10'd1;
            state_nxt = SC_BLK_ISSUE;
          end
        end
      end

      CLR_ISSUE: begin
        sel_c     = 1'b1;
        we_c      = 1'b1;
        addr_c    = addr;
        din_c     = BLANK;
        state_nxt = CLR_WAIT;
      end

      CLR_WAIT: begin
        if (v_rdy) begin
          if (addr == LAST_ADDR) begin
            col_nxt   = '0;
            row_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            addr_nxt  = addr + 10'd1;
            state_nxt = CLR_ISSUE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced to zero while reset is asserted so nothing leaks
  // onto the bus in the reset cycle itself.
  always_comb begin
    char_ready = ready_c & ~reset;
    v_sel      = sel_c & ~reset;
    v_we       = we_c & ~reset;
    v_addr     = reset ? 10'd0 : addr_c;
    v_din      = reset ? 8'd0 : din_c;
    cursor_col = reset ? 5'd0 : col;
    cursor_row = reset ? 5'd0 : row;
    busy       = (state != IDLE) & ~reset;
  end

endmodule

// File: tb/tb_vid_term.sv
// Self-checking bench for vid_term: behavioural video-buffer model with
// optional deferrals, a screen-level reference model feeding an access
// scoreboard, and direct checks of cursor, latency and memory contents.
module tb_vid_term;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       v_sel, v_we;
  logic [9:0] v_addr;
  logic [7:0] v_din;
  logic [7:0] v_dout;
  logic       v_rdy;
  logic [4:0] cursor_col, cursor_row;
  logic       busy;

  vid_term dut (
    .clk(clk), .reset(reset),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .v_sel(v_sel), .v_we(v_we), .v_addr(v_addr), .v_din(v_din),
    .v_dout(v_dout), .v_rdy(v_rdy),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #31 clk = ~clk;

  // Video buffer model: writes land even when deferred; reads are
  // registered and stay on v_dout until the next read.
  logic [7:0] mem [1024];
  logic [7:0] img [1024];
  logic       load_req = 1'b0;
  logic [1:0] stall = 2'd0;
  bit         stall_en = 1'b0;

  assign v_rdy = (stall == 2'd0);

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
    end else if (v_sel) begin
      if (v_we) mem[v_addr] <= v_din;
      else      v_dout <= mem[v_addr];
    end
    if (reset)
      stall <= 2'd0;
    else if (v_sel)
      stall <= (stall_en && $urandom_range(0, 2) == 0) ? 2'd2 : 2'd0;
    else if (stall != 2'd0)
      stall <= stall - 2'd1;
  end

  typedef struct packed {
    logic       we;
    logic [9:0] addr;
    logic [7:0] din;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] ref_mem [1024];
  int         ref_col, ref_row;
  int         checks = 0, errors = 0, sel_count = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // ---------------- reference model (screen level) ----------------
  task automatic exp_write(input int a, input int d);
    acc_t e;
    e.we = 1'b1; e.addr = 10'(a); e.din = 8'(d);
    exp_q.push_back(e);
    ref_mem[a] = 8'(d);
  endtask

  task automatic model_scroll();
    acc_t e;
    for (int src = 32; src < 896; src++) begin
      e.we = 1'b0; e.addr = 10'(src); e.din = 8'h00;
      exp_q.push_back(e);
      exp_write(src - 32, int'(ref_mem[src]));
    end
    for (int a = 864; a < 896; a++) exp_write(a, 32);
  endtask

  task automatic model_lf();
    if (ref_row < 27) ref_row++;
    else model_scroll();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20) begin
      exp_write(ref_row * 32 + ref_col, int'(b));
      if (ref_col < 31) ref_col++;
      else begin ref_col = 0; model_lf(); end
    end else begin
      case (b)
        8'h0D: ref_col = 0;
        8'h0A: model_lf();
        8'h08: if (ref_col > 0) ref_col--;
        8'h0C: begin
          for (int a = 0; a < 896; a++) exp_write(a, 32);
          ref_col = 0; ref_row = 0;
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    acc_t e;
    bit   prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && v_sel) begin
        sel_count++;
        check(!prev && stall == 2'd0, "no_reissue", int'(prev), 0);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_access", int'(v_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check(v_we == e.we && v_addr == e.addr && (!e.we || v_din == e.din),
                "bus_access", int'({v_we, v_addr, v_din}), int'({e.we, e.addr, e.din}));
        end
      end
      prev = v_sel;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic accept_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 20000) begin @(negedge clk); n++; end
    if (!char_ready) begin
      check(1'b0, "ready_timeout", 0, 1);
      return;
    end
    char_valid = 1'b1;
    char_data  = b;
    @(posedge clk);
    model_byte(b);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      char_valid = 1'b0;
      lat++;
      if (busy) bcnt++;
    end while (!char_ready && lat < 20000);
    if (!char_ready) check(1'b0, "done_timeout", lat, 0);
    check(cursor_col == 5'(ref_col) && cursor_row == 5'(ref_row), "cursor",
          int'({cursor_row, cursor_col}), ref_row * 32 + ref_col);
    check(exp_q.size() == 0, "accesses_drained", exp_q.size(), 0);
  endtask

  task automatic send(input logic [7:0] b, output int lat, output int bcnt);
    accept_byte(b);
    wait_done(lat, bcnt);
  endtask

  // mode 0: random; mode 1: row r holds r, rows 28..31 hold 0xA5
  task automatic load_image(input int mode);
    for (int i = 0; i < 1024; i++) begin
      if (mode == 0) img[i] = 8'($urandom);
      else           img[i] = (i < 896) ? 8'(i / 32) : 8'hA5;
      ref_mem[i] = img[i];
    end
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
  endtask

  function automatic logic [7:0] scrolled(input int a);
    int r = a / 32;
    if (r < 27)  return 8'(r + 1);
    if (r == 27) return 8'h20;
    return 8'hA5;
  endfunction

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32, 255));
    if (r < 78) return 8'h0D;
    if (r < 86) return 8'h08;
    if (r < 92) return 8'h0A;
    if (r < 94) return 8'h0C;
    return 8'($urandom_range(0, 31));
  endfunction

  initial begin
    int lat, bcnt, bad, sc0;
    reset = 1'b1; char_valid = 1'b0; char_data = 8'h00;
    ref_col = 0; ref_row = 0;
    fork monitor(); join_none
    load_image(0);
    @(posedge clk);
    #1;
    check({char_ready, v_sel, v_we, v_addr, v_din, cursor_col, cursor_row, busy} == '0,
          "reset_outputs", int'({char_ready, v_sel, busy}), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check(char_ready == 1'b1, "ready_after_reset", int'(char_ready), 1);

    // single printable
    send(8'h41, lat, bcnt);
    check(lat == 3, "put_latency", lat, 3);
    check(cursor_col == 5'd1 && cursor_row == 5'd0, "cursor_after_A", int'(cursor_col), 1);

    // clear screen
    send(8'h0C, lat, bcnt);
    check(bcnt == 1792, "clear_busy_cycles", bcnt, 1792);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] != ((i < 896) ? 8'h20 : ref_mem[i])) bad++;
    check(bad == 0, "clear_memory", bad, 0);

    // full row of 'B' wraps
    for (int i = 0; i < 32; i++) send(8'h42, lat, bcnt);
    check(cursor_col == 5'd0 && cursor_row == 5'd1, "row_wrap", int'({cursor_row, cursor_col}), 32);

    // move to (5,3), then CR / LF / BS without bus traffic
    send(8'h0A, lat, bcnt);
    send(8'h0A, lat, bcnt);
    for (int i = 0; i < 5; i++) send(8'h78, lat, bcnt);
    sc0 = sel_count;
    send(8'h0D, lat, bcnt);
    check(lat == 1, "cr_latency", lat, 1);
    check(cursor_col == 5'd0 && cursor_row == 5'd3, "cr_cursor", int'({cursor_row, cursor_col}), 96);
    send(8'h0A, lat, bcnt);
    check(cursor_col == 5'd0 && cursor_row == 5'd4, "lf_cursor", int'({cursor_row, cursor_col}), 128);
    send(8'h08, lat, bcnt);
    check(cursor_col == 5'd0 && cursor_row == 5'd4, "bs_at_col0", int'({cursor_row, cursor_col}), 128);
    check(sel_count == sc0, "no_bus_for_controls", sel_count - sc0, 0);

    // unstalled scroll from row 27
    for (int i = 0; i < 23; i++) send(8'h0A, lat, bcnt);
    load_image(1);
    send(8'h0A, lat, bcnt);
    check(bcnt == 3520, "scroll_busy_cycles", bcnt, 3520);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != scrolled(i)) bad++;
    check(bad == 0, "scroll_memory", bad, 0);

    // same scroll with random deferrals
    load_image(1);
    stall_en = 1'b1;
    send(8'h0A, lat, bcnt);
    stall_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != scrolled(i)) bad++;
    check(bad == 0, "stalled_scroll_memory", bad, 0);

    // printable at (31,27): put, then scroll
    for (int i = 0; i < 31; i++) send(8'h79, lat, bcnt);
    send(8'h5A, lat, bcnt);
    check(bcnt == 3522, "wrap_scroll_busy", bcnt, 3522);
    check(cursor_col == 5'd0 && cursor_row == 5'd27, "wrap_scroll_cursor",
          int'({cursor_row, cursor_col}), 27 * 32);

    // random stream with deferrals
    stall_en = 1'b1;
    for (int n = 0; n < 80; n++) send(rand_byte(), lat, bcnt);
    stall_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != ref_mem[i]) bad++;
    check(bad == 0, "random_memory", bad, 0);

    // reset in the middle of a clear
    load_image(1);
    accept_byte(8'h0C);
    @(negedge clk);
    char_valid = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    check({char_ready, v_sel, v_we, v_addr, v_din, cursor_col, cursor_row, busy} == '0,
          "midop_reset_outputs", int'({char_ready, v_sel, busy}), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    ref_col = 0; ref_row = 0;
    sc0 = sel_count;
    repeat (20) @(negedge clk);
    check(sel_count == sc0, "no_access_after_reset", sel_count - sc0, 0);
    check(char_ready && !busy && cursor_col == 5'd0 && cursor_row == 5'd0,
          "idle_after_reset", int'({char_ready, busy, cursor_row, cursor_col}), 1 << 11);
    check(mem[0] == 8'h20 && mem[895] == 8'd27, "partial_clear_kept",
          int'({mem[0], mem[895]}), int'({8'h20, 8'd27}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
